bp_stall_hist_counters: RTL
===========================

# bp_stall_hist_counters

Synthesizable stall-reason histogram that sits directly downstream of the core stall-reason encoder. Each enabled cycle it consumes the encoded stall reason plus the commit instret flag. It accumulates per-reason counters, a retired-instruction counter and an enabled-cycle counter. Counts are read out through a one-entry ready/valid read port, so software or a debug bus can sample them without simulation-only constructs.

## Interface
Parameters:
- num_reasons_p, 27, number of stall reasons; reason 0 is "unknown".
- reason_width_p, 5, width of the reason code; must satisfy 2^reason_width_p >= num_reasons_p + 2.
- cnt_width_p, 32, width of every counter.

Ports:
- clk_i  in  1  clock.
- reset_li  in  1  reset, asynchronous, active-low.
- en_i  in  1  profiling enable; low while frozen or in reset-drain.
- instret_i  in  1  an instruction committed this cycle.
- stall_v_i  in  1  stall_reason_i is valid.
- stall_reason_i  in  reason_width_p  encoded stall reason.
- clear_i  in  1  synchronous clear of all counters and the overflow flag.
- rd_v_i  in  1  read request valid.
- rd_addr_i  in  reason_width_p  address to read: 0..num_reasons_p-1 are reasons, num_reasons_p is the instret counter, num_reasons_p+1 is the cycle counter.
- rd_ready_and_o  out  1  read request accepted when high together with rd_v_i.
- rd_v_o  out  1  read data valid.
- rd_data_o  out  cnt_width_p  read data.
- rd_yumi_i  in  1  consumer takes the read data.
- overflow_o  out  1  sticky: some counter has saturated.

## Operation
- Update rules, all evaluated in the same cycle:
  - Cycle counter increments when en_i=1.
  - Instret counter increments when en_i=1 and instret_i=1.
  - Reason counter hist[r] increments when en_i=1 and instret_i=0. Here r = stall_reason_i if stall_v_i=1 and stall_reason_i < num_reasons_p; otherwise r = 0 (unknown).
- Exactly one of {instret, one reason} increments per enabled cycle. Therefore, with no saturation, the sum of all reason counters plus the instret counter equals the cycle counter.
- clear_i has priority over every increment in the same cycle: all counters become 0 and overflow_o becomes 0.
- Read port:
  - One-entry output buffer; rd_ready_and_o = ~rd_v_o | rd_yumi_i.
  - On an accepted request, rd_data_o is loaded with the addressed counter's current registered value and rd_v_o is set.
  - An out-of-range address (> num_reasons_p+1) returns 0.
  - rd_yumi_i without a new accept clears rd_v_o; rd_data_o holds its last value.
- Read and increment of the same counter in the same cycle returns the pre-increment value.
- Read accepted in the same cycle as clear_i returns the pre-clear value.
- rd_yumi_i asserted while rd_v_o=0 is ignored.

## Timing
- Read latency: 1 cycle from accept to rd_v_o=1. Back-to-back reads are sustained at 1 per cycle when rd_yumi_i is held high.
- Counter update is visible to a read accepted on the next cycle.
- Reset (reset_li=0, asynchronous): all counters 0, rd_v_o=0, rd_data_o=0, overflow_o=0, rd_ready_and_o=1.
- Reset asserted mid-read discards the pending read data; no response is produced after reset releases.
- overflow_o rises the cycle after the first saturating increment and stays high until clear_i or reset.

## Configuration
- BP_STALL_HIST_SAT_EN defined:
  - Counters saturate at 2^cnt_width_p-1.
  - An increment attempted at that value leaves the counter at max and sets overflow_o.
- Undefined:
  - Counters wrap modulo 2^cnt_width_p.
  - overflow_o is tied 0.

## Test plan
- Reset, then en_i=1 for 10 cycles with instret_i=1 on 4 of them and stall_v_i=1, reason=7 on the other 6 -> reads return addr 7=6, addr 27=4, addr 28=10, all other reason addresses=0.
- en_i=1, instret_i=0, stall_v_i=0 for 3 cycles, then reason=30 (out of range) for 2 cycles -> addr 0 reads 5.
- Same-cycle increment of reason 3 and accepted read of addr 3 -> returns the old value; a read on the next cycle returns old+1. clear_i together with an increment -> all counters read 0 afterwards.
- Read backpressure: accept read of addr 28 with rd_yumi_i=0 for 3 cycles -> rd_ready_and_o=0, rd_data_o stable; a new request is accepted in the rd_yumi_i cycle and rd_v_o stays 1 with the new data next cycle.
- cnt_width_p=4, 20 stalls on reason 1 -> with BP_STALL_HIST_SAT_EN: reads 15, overflow_o=1. Without: reads 4, overflow_o=0.
- Drop reset_li asynchronously while rd_v_o=1 -> rd_v_o=0 immediately, all counters 0, overflow_o=0.

Source files
------------

// File: rtl/bp_stall_hist_counters.sv
// Stall-reason histogram with instret/cycle counters; BP_STALL_HIST_SAT_EN selects saturating counters.
// Latency: a read returns the addressed counter's registered value one cycle after accept.
// Backpressure: one-entry read buffer, rd_ready_and_o = ~rd_v_o | rd_yumi_i.
module bp_stall_hist_counters
  #(parameter int num_reasons_p  = 27
   ,parameter int reason_width_p = 5
   ,parameter int cnt_width_p    = 32
   )
   (input  logic                      clk_i
   ,input  logic                      reset_li
   ,input  logic                      en_i
   ,input  logic                      instret_i
   ,input  logic                      stall_v_i
   ,input  logic [reason_width_p-1:0] stall_reason_i
   ,input  logic                      clear_i
   ,input  logic                      rd_v_i
   ,input  logic [reason_width_p-1:0] rd_addr_i
   ,output logic                      rd_ready_and_o
   ,output logic                      rd_v_o
   ,output logic [cnt_width_p-1:0]    rd_data_o
   ,input  logic                      rd_yumi_i
   ,output logic                      overflow_o
   );

   localparam int num_cnt_lp     = num_reasons_p + 2;
   localparam int instret_idx_lp = num_reasons_p;
   localparam int cycle_idx_lp   = num_reasons_p + 1;
   localparam logic [reason_width_p-1:0] num_reasons_lp = reason_width_p'(num_reasons_p);

   logic [cnt_width_p-1:0]    cnt_r [num_cnt_lp];
   logic [cnt_width_p-1:0]    cnt_n [num_cnt_lp];
   logic [num_cnt_lp-1:0]     inc;
   logic [reason_width_p-1:0] reason_sel;
   logic [cnt_width_p-1:0]    rd_sel;
   logic                      rd_v_r;
   logic [cnt_width_p-1:0]    rd_data_r;
   logic                      rd_accept;

   // Invalid or out-of-range reasons are charged to reason 0 (unknown).
   always_comb begin
      reason_sel = '0;
      if (stall_v_i && (stall_reason_i < num_reasons_lp))
         reason_sel = stall_reason_i;
   end

   always_comb begin
      inc = '0;
      for (int i = 0; i < num_reasons_p; i++)
         inc[i] = en_i & ~instret_i & (reason_sel == reason_width_p'(i));
      inc[instret_idx_lp] = en_i & instret_i;
      inc[cycle_idx_lp]   = en_i;
   end

`ifdef BP_STALL_HIST_SAT_EN
   logic sat_hit;
   logic overflow_r;

   always_comb begin
      sat_hit = 1'b0;
      for (int i = 0; i < num_cnt_lp; i++) begin
         cnt_n[i] = cnt_r[i] + cnt_width_p'(inc[i]);
         if (inc[i] && (cnt_r[i] == '1)) begin
            cnt_n[i] = cnt_r[i];
            sat_hit  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_li) begin
      if (!reset_li)
         overflow_r <= 1'b0;
      else if (clear_i)
         overflow_r <= 1'b0;
      else if (sat_hit)
         overflow_r <= 1'b1;
   end

   assign overflow_o = overflow_r;
`else
   always_comb begin
      for (int i = 0; i < num_cnt_lp; i++)
         cnt_n[i] = cnt_r[i] + cnt_width_p'(inc[i]);
   end

   assign overflow_o = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge reset_li) begin
      if (!reset_li) begin
         for (int i = 0; i < num_cnt_lp; i++)
            cnt_r[i] <= '0;
      end
      else if (clear_i) begin
         for (int i = 0; i < num_cnt_lp; i++)
            cnt_r[i] <= '0;
      end
      else begin
         for (int i = 0; i < num_cnt_lp; i++)
            cnt_r[i] <= cnt_n[i];
      end
   end

   // Unmatched addresses fall through to zero.
   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < num_cnt_lp; i++)
         if (rd_addr_i == reason_width_p'(i))
            rd_sel = cnt_r[i];
   end

   assign rd_ready_and_o = ~rd_v_r | rd_yumi_i;
   assign rd_accept      = rd_v_i & rd_ready_and_o;

   always_ff @(posedge clk_i or negedge reset_li) begin
      if (!reset_li) begin
         rd_v_r    <= 1'b0;
         rd_data_r <= '0;
      end
      else if (rd_accept) begin
         rd_v_r    <= 1'b1;
         rd_data_r <= rd_sel;
      end
      else if (rd_yumi_i) begin
         rd_v_r    <= 1'b0;
      end
   end

   assign rd_v_o    = rd_v_r;
   assign rd_data_o = rd_data_r;

endmodule
